// File: rtl/msrv32_imm_pkg.sv
// rtl/msrv32_imm_pkg.sv - immediate format codes shared by the MSRV32 immediate generator
package msrv32_imm_pkg;

  localparam logic [3:0] IMM_I      = 4'd0;
  localparam logic [3:0] IMM_S      = 4'd2;
  localparam logic [3:0] IMM_B      = 4'd3;
  localparam logic [3:0] IMM_U      = 4'd4;
  localparam logic [3:0] IMM_J      = 4'd5;
  localparam logic [3:0] IMM_CSR    = 4'd6;
  localparam logic [3:0] IMM_CI     = 4'd8;
  localparam logic [3:0] IMM_CI_LUI = 4'd9;
  localparam logic [3:0] IMM_LWSP   = 4'd10;
  localparam logic [3:0] IMM_SWSP   = 4'd11;
  localparam logic [3:0] IMM_CIW    = 4'd12;
  localparam logic [3:0] IMM_CL     = 4'd13;
  localparam logic [3:0] IMM_CB     = 4'd14;
  localparam logic [3:0] IMM_CJ     = 4'd15;

endpackage

// File: rtl/msrv32_imm_expand.sv
// rtl/msrv32_imm_expand.sv - combinational immediate extraction and extension
module msrv32_imm_expand
  import msrv32_imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RVC_EN = 1
) (
  input  logic [31:0]     instr,
  input  logic [3:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // The two opcode LSBs never carry immediate bits in any format.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^instr[1:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    if (imm_type[3] && (RVC_EN == 0)) begin
      illegal = 1'b1;
    end else begin
      case (imm_type)
        IMM_I, 4'd1, 4'd7:
          imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
        IMM_S:
          imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
        IMM_B:
          imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_U:
          imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'h000};
        IMM_J:
          imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        IMM_CSR:
          imm = {{(XLEN-5){1'b0}}, instr[19:15]};
        IMM_CI:
          imm = {{(XLEN-6){instr[12]}}, instr[12], instr[6:2]};
        IMM_CI_LUI:
          imm = {{(XLEN-18){instr[12]}}, instr[12], instr[6:2], 12'h000};
        IMM_LWSP:
          imm = {{(XLEN-8){1'b0}}, instr[3:2], instr[12], instr[6:4], 2'b00};
        IMM_SWSP:
          imm = {{(XLEN-8){1'b0}}, instr[8:7], instr[12:9], 2'b00};
        IMM_CIW:
          imm = {{(XLEN-10){1'b0}}, instr[10:7], instr[12:11], instr[5], instr[6], 2'b00};
        IMM_CL:
          imm = {{(XLEN-7){1'b0}}, instr[5], instr[12:10], instr[6], 2'b00};
        IMM_CB:
          imm = {{(XLEN-9){instr[12]}}, instr[12], instr[6:5], instr[2], instr[11:10],
                 instr[4:3], 1'b0};
        default:
          imm = {{(XLEN-12){instr[12]}}, instr[12], instr[8], instr[10:9], instr[6], instr[7],
                 instr[2], instr[11], instr[5:3], 1'b0};
      endcase
    end
  end

endmodule

// File: rtl/msrv32_imm_gen_pipe.sv
// rtl/msrv32_imm_gen_pipe.sv - immediate generator with a two-entry elastic output buffer
module msrv32_imm_gen_pipe
  import msrv32_imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RVC_EN = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            flush_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_in,
  input  logic [3:0]      imm_type_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            illegal_out
);

  logic [XLEN-1:0] exp_imm;
  logic            exp_ill;

  msrv32_imm_expand #(.XLEN(XLEN), .RVC_EN(RVC_EN)) u_expand (
    .instr    (instr_in),
    .imm_type (imm_type_in),
    .imm      (exp_imm),
    .illegal  (exp_ill)
  );

  logic            or_valid, sr_valid;
  logic [XLEN-1:0] or_imm, sr_imm;
  logic            or_ill, sr_ill;
  logic            accept, or_free;

  // in_ready depends only on the skid register, so out_ready never reaches it.
  assign in_ready = !sr_valid && !rst_in;
  assign accept   = in_valid && in_ready && !flush_in;
  assign or_free  = !or_valid || out_ready;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
      or_imm   <= '0;
      or_ill   <= 1'b0;
      sr_imm   <= '0;
      sr_ill   <= 1'b0;
    end else if (flush_in) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
    end else begin
      if (or_free) begin
        if (sr_valid) begin
          or_valid <= 1'b1;
          or_imm   <= sr_imm;
          or_ill   <= sr_ill;
          sr_valid <= 1'b0;
        end else if (accept) begin
          or_valid <= 1'b1;
          or_imm   <= exp_imm;
          or_ill   <= exp_ill;
        end else begin
          or_valid <= 1'b0;
        end
      end else if (accept) begin
        sr_valid <= 1'b1;
        sr_imm   <= exp_imm;
        sr_ill   <= exp_ill;
      end
    end
  end

  assign out_valid   = or_valid;
  assign imm_out     = or_imm;
  assign illegal_out = or_ill;

endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
// tb/tb_msrv32_imm_gen_pipe.sv - directed scoreboard bench for the pipelined immediate generator
module tb_msrv32_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] instr = '0;
  logic [3:0]  imm_type = '0;
  logic        in_ready, out_valid, illegal;
  logic [31:0] imm;

  logic        in_valid64 = 1'b0, out_ready64 = 1'b1;
  logic [31:0] instr64 = '0;
  logic [3:0]  imm_type64 = '0;
  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] imm64;

  int n_asserts = 0;
  int n_fail = 0;
  logic [32:0] sb[$];
  logic [31:0] pend_imm;
  logic        pend_ill;

  always #5 clk = ~clk;

  msrv32_imm_gen_pipe #(.XLEN(32), .RVC_EN(1)) dut32 (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instr_in(instr), .imm_type_in(imm_type),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm), .illegal_out(illegal)
  );

  msrv32_imm_gen_pipe #(.XLEN(64), .RVC_EN(0)) dut64 (
    .clk_in(clk), .rst_in(rst), .flush_in(flush),
    .in_valid(in_valid64), .in_ready(in_ready64), .instr_in(instr64), .imm_type_in(imm_type64),
    .out_valid(out_valid64), .out_ready(out_ready64), .imm_out(imm64), .illegal_out(illegal64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] i, input logic [3:0] t,
                       input logic [31:0] e, input logic el);
    in_valid = 1'b1;
    instr    = i;
    imm_type = t;
    pend_imm = e;
    pend_ill = el;
  endtask

  // Records handshakes seen just before the edge, then advances one cycle.
  task automatic tick();
    logic [32:0] head;
    if (in_valid && in_ready && !flush && !rst) sb.push_back({pend_ill, pend_imm});
    if (out_valid && out_ready && !flush && !rst) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        head = sb.pop_front();
        check("stream_imm", {32'd0, imm}, {32'd0, head[31:0]});
        check("stream_ill", {63'd0, illegal}, {63'd0, head[32]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step64(input logic [31:0] i, input logic [3:0] t,
                        input logic [63:0] e, input logic el);
    in_valid64 = 1'b1;
    instr64    = i;
    imm_type64 = t;
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    check("x64_valid", {63'd0, out_valid64}, 64'd1);
    check("x64_imm", imm64, e);
    check("x64_ill", {63'd0, illegal64}, {63'd0, el});
  endtask

  initial begin
    tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_imm", {32'd0, imm}, 64'd0);
    check("rst_ill", {63'd0, illegal}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    step64(32'h800000B7, 4'd4, 64'hFFFFFFFF80000000, 1'b0);
    step64(32'h000F9073, 4'd6, 64'h000000000000001F, 1'b0);
    step64(32'h000010FD, 4'd8, 64'h0, 1'b1);
    step64(32'h7FF00013, 4'd0, 64'h00000000000007FF, 1'b0);
    @(posedge clk);
    #1;

    out_ready = 1'b1;
    offer(32'hFFF00093, 4'd1, 32'hFFFFFFFF, 1'b0); tick();
    check("latency_valid", {63'd0, out_valid}, 64'd1);
    offer(32'hFE000EE3, 4'd3, 32'hFFFFFFFC, 1'b0); tick();
    offer(32'h000010FD, 4'd8, 32'hFFFFFFFF, 1'b0); tick();
    offer(32'h00005C60, 4'd13, 32'h0000007C, 1'b0); tick();
    offer(32'h00112623, 4'd2, 32'h0000000C, 1'b0); tick();
    offer(32'hFFDFF06F, 4'd5, 32'hFFFFFFFC, 1'b0); tick();
    offer(32'h80000013, 4'd7, 32'hFFFFF800, 1'b0); tick();
    offer(32'h00000005, 4'd9, 32'h00001000, 1'b0); tick();
    offer(32'h0000000C, 4'd10, 32'h000000C0, 1'b0); tick();
    offer(32'h00000180, 4'd11, 32'h000000C0, 1'b0); tick();
    offer(32'h00000780, 4'd12, 32'h000003C0, 1'b0); tick();
    offer(32'h00001000, 4'd14, 32'hFFFFFF00, 1'b0); tick();
    offer(32'h00001000, 4'd15, 32'hFFFFF800, 1'b0); tick();
    offer(32'h000F9073, 4'd6, 32'h0000001F, 1'b0); tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);
    check("drain_sb", 64'(sb.size()), 64'd0);

    out_ready = 1'b0;
    offer(32'h00100093, 4'd0, 32'h00000001, 1'b0);
    check("bp_ready_a", {63'd0, in_ready}, 64'd1);
    tick();
    offer(32'hFFE00093, 4'd0, 32'hFFFFFFFE, 1'b0);
    check("bp_ready_b", {63'd0, in_ready}, 64'd1);
    tick();
    offer(32'h00300093, 4'd0, 32'h00000003, 1'b0);
    check("bp_ready_c", {63'd0, in_ready}, 64'd0);
    tick();
    check("bp_hold_imm0", {32'd0, imm}, 64'h1);
    tick();
    check("bp_hold_imm1", {32'd0, imm}, 64'h1);
    check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    check("bp_empty_valid", {63'd0, out_valid}, 64'd0);
    check("bp_sb", 64'(sb.size()), 64'd0);

    out_ready = 1'b0;
    offer(32'h00500093, 4'd0, 32'h00000005, 1'b0); tick();
    offer(32'h00600093, 4'd0, 32'h00000006, 1'b0); tick();
    offer(32'h00700093, 4'd0, 32'h00000007, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    tick();
    check("flush_dropped", {63'd0, out_valid}, 64'd0);

    out_ready = 1'b0;
    offer(32'h00800093, 4'd0, 32'h00000008, 1'b1); tick();
    offer(32'h00900093, 4'd0, 32'h00000009, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    sb.delete();
    in_valid = 1'b0;
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_imm", {32'd0, imm}, 64'd0);
    check("mid_rst_ill", {63'd0, illegal}, 64'd0);
    check("mid_rst_in_ready_hi", {63'd0, in_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_imm_gen_pipe.md
# msrv32_imm_gen_pipe

Parametrised, pipelined immediate generator for the MSRV32 decode stage. It extracts and sign- or zero-extends immediates from 32-bit base instructions and, optionally, from 16-bit RVC instructions, producing XLEN-wide results. A two-entry elastic buffer with valid/ready handshakes on both sides decouples decode from the register-read/execute boundary. It supersedes the purely combinational 32-bit generator.

## Interface
- XLEN, 32: result width; legal values are 32 and 64.
- RVC_EN, 1: 1 enables the compressed immediate formats (type codes 8–15).
- clk_in  input  1  clock; all logic on the rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- flush_in  input  1  synchronous pipeline flush.
- in_valid  input  1  a request is present.
- in_ready  output  1  the request is accepted this cycle when in_valid && in_ready.
- instr_in  input  32  instruction; RVC instructions occupy bits [15:0].
- imm_type_in  input  4  immediate format code.
- out_valid  output  1  imm_out is valid.
- out_ready  input  1  downstream accepts when out_valid && out_ready.
- imm_out  output  XLEN  extended immediate.
- illegal_out  output  1  the format code is unsupported; imm_out is 0.

## Operation
- Base codes:
  - 0 and 1: I-format, sext(i[31:20]).
  - 2: S-format, sext({i[31:25], i[11:7]}).
  - 3: B-format, sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - 4: U-format, sext({i[31:12], 12'h0}).
  - 5: J-format, sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - 6: CSR, zext(i[19:15]).
  - 7: I-format.
- RVC codes:
  - 8 CI: sext({i[12], i[6:2]}).
  - 9 CI-LUI: sext({i[12], i[6:2], 12'h0}).
  - 10 LWSP: zext({i[3:2], i[12], i[6:4], 00}).
  - 11 SWSP: zext({i[8:7], i[12:9], 00}).
  - 12 CIW: zext({i[10:7], i[12:11], i[5], i[6], 00}).
  - 13 CL/CS: zext({i[5], i[12:10], i[6], 00}).
  - 14 CB: sext({i[12], i[6:5], i[2], i[11:10], i[4:3], 0}).
  - 15 CJ: sext({i[12], i[8], i[10:9], i[6], i[7], i[2], i[11], i[5:3], 0}).
- "sext" replicates the MSB up to XLEN; "zext" fills with zeros.
- When RVC_EN=0, codes 8–15 give imm_out=0 with illegal_out=1. In every other case illegal_out=0.
- Expansion happens before the buffer. The buffer stores {imm, illegal}.
- The buffer has an output register (OR) and a skid register (SR). in_ready = !SR_valid && !rst_in.
  - Accept with OR empty, or with OR being drained this cycle: the entry goes to OR.
  - Accept with OR full and not draining: the entry goes to SR.
  - When OR drains and SR is full: SR moves to OR.
  - Ordering is strictly FIFO. No entry is ever lost or duplicated.
- flush_in: both entries are invalidated at the next edge. Any in_valid in the same cycle is discarded. Flush beats accept.
- rst_in beats flush_in.

## Timing
- Latency: an entry accepted at edge N appears on out_valid/imm_out after edge N (1 cycle).
- Throughput: 1 per cycle while out_ready=1.
- Reset values: out_valid=0, imm_out=0, illegal_out=0. in_ready=0 while rst_in is high, and 1 in the first cycle after reset.
- in_ready is registered-derived only; there is no combinational path from out_ready.
- imm_out and illegal_out hold stable while out_valid && !out_ready.
- Reset or flush mid-stall: the buffer is empty after the edge, and out_valid=0 the next cycle.

## Structure
- Package msrv32_imm_pkg holds:
  - IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR;
  - IMM_CI, IMM_CI_LUI, IMM_LWSP, IMM_SWSP, IMM_CIW, IMM_CL, IMM_CB, IMM_CJ (4-bit localparams).
- Sub-module msrv32_imm_expand (combinational; XLEN and RVC_EN parameters) decodes instr/type into {imm, illegal}. The top level holds the two-entry buffer and control.

## Test plan
- XLEN=32, type 1, instr 0xFFF00093 -> imm_out=0xFFFFFFFF one cycle later. Type 3, instr 0xFE000EE3 -> 0xFFFFFFFC.
- XLEN=64, type 4, instr 0x800000B7 -> 0xFFFFFFFF80000000. Type 6, instr 0x000F9073 -> 0x1F.
- RVC_EN=1: type 8, instr 0x10FD -> 0xFFFFFFFF. Type 13, instr 0x5C60 -> 0x7C. RVC_EN=0: type 8 -> imm 0, illegal_out=1.
- Backpressure: hold out_ready=0 and offer 3 back-to-back requests -> 2 accepted, and in_ready=0 on the third. Release out_ready -> outputs in order, one per cycle, with held values stable during the stall.
- Assert flush_in with both entries full and in_valid=1 -> out_valid=0 next cycle, the incoming request is dropped, and in_ready=1.
- Assert rst_in mid-stream -> all outputs reach their reset values after the edge, and in_ready=0 during reset.
